// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm: multi-cycle control sequencer for the MIPS datapath with a data-memory handshake.
// Define MIPS_CTRL_PERF_EN to build the cycle/instret performance counters; otherwise both read 0.
`ifndef OP_RTYPE
`define OP_RTYPE 6'b000000
`endif
`ifndef OP_J
`define OP_J     6'b000010
`endif
`ifndef OP_BEQ
`define OP_BEQ   6'b000100
`endif
`ifndef OP_ADDI
`define OP_ADDI  6'b001000
`endif
`ifndef OP_LUI
`define OP_LUI   6'b001111
`endif
`ifndef OP_LW
`define OP_LW    6'b100011
`endif
`ifndef OP_SW
`define OP_SW    6'b101011
`endif

module mips_ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_imm,
    output logic        reg_dst_rd,
    output logic        reg_write_enable,
    output logic        mem_to_reg,
    output logic        dmem_req,
    output logic        dmem_write,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    `OP_J: retire = 1'b1;
                    `OP_RTYPE, `OP_ADDI, `OP_LUI, `OP_LW, `OP_SW, `OP_BEQ: state_d = S_EXECUTE;
                    default: state_d = S_HALT;
                endcase
            end
            S_EXECUTE: begin
                case (op_q)
                    `OP_BEQ:       retire  = 1'b1;
                    `OP_LW, `OP_SW: state_d = S_MEM;
                    default:       state_d = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == `OP_SW) retire = 1'b1;
                    else                state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: retire = 1'b1;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase
        // run is sampled only at the retire boundary, overriding the per-state next state.
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    always_comb begin
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = 2'd0;
        alu_src_imm      = 1'b0;
        reg_dst_rd       = 1'b0;
        reg_write_enable = 1'b0;
        mem_to_reg       = 1'b0;
        dmem_req         = 1'b0;
        dmem_write       = 1'b0;
        halted           = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            // op_q is not yet valid in DECODE, so the jump decode reads the IR opcode directly.
            S_DECODE: begin
                if (opcode == `OP_J) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                end
            end
            S_EXECUTE: begin
                alu_src_imm = (op_q == `OP_ADDI) || (op_q == `OP_LUI) ||
                              (op_q == `OP_LW)   || (op_q == `OP_SW);
                if (op_q == `OP_BEQ) begin
                    pc_src   = 2'd1;
                    pc_write = alu_zero;
                end
            end
            S_MEM: begin
                dmem_req   = 1'b1;
                dmem_write = (op_q == `OP_SW);
            end
            S_WRITEBACK: begin
                reg_write_enable = 1'b1;
                reg_dst_rd       = (op_q == `OP_RTYPE);
                mem_to_reg       = (op_q == `OP_LW);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] instret_count_q, instret_count_d;

    always_comb begin
        cycle_count_d   = cycle_count_q;
        instret_count_d = instret_count_q;
        if (state_q != S_IDLE && state_q != S_HALT) cycle_count_d = cycle_count_q + 32'd1;
        if (retire) instret_count_d = instret_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count_q   <= '0;
            instret_count_q <= '0;
        end else begin
            cycle_count_q   <= cycle_count_d;
            instret_count_q <= instret_count_d;
        end
    end

    assign cycle_count   = cycle_count_q;
    assign instret_count = instret_count_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule
